// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, iteration count and small operand helpers.
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_SIGN = 2'b10
   } state_e;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 6;

   function automatic logic is_div(input op_e o);
      return o[1];
   endfunction

   function automatic logic is_signed(input op_e o);
      return ~o[0];
   endfunction

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_addsub.sv
// 33-bit adder/subtractor with carry out, shared by the multiply (add)
// and restoring-divide (trial subtract) iterations.
module mdu_addsub (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        sub,
   output logic [32:0] sum,
   output logic        carry
);

   logic [32:0] b_eff;

   assign b_eff        = sub ? ~b : b;
   // On subtract, carry=1 means a >= b (no borrow).
   assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {33'd0, sub};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
// stepping on the falling clock edge and freezable by enableDebug.
module mult_div_unit
   import mult_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enableDebug,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        writeHi,
   input  logic        writeLo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        divByZero,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   state_e            state, next_state;
   logic [CNT_W-1:0]  count;
   op_e               op_q;
   logic              neg_q, rem_neg_q;
   logic [31:0]       hi_acc, lo_acc, opnd;

   op_e               op_in;
   logic              zero_divisor, last_iter;
   logic              load, div_zero, iterate, finish, mtx_ok;

   logic [32:0]       add_a, add_sum, mul_sum;
   logic              add_carry;
   logic [31:0]       hi_step, lo_step, res_hi, res_lo;
   logic [63:0]       product;

   assign op_in        = op_e'(op);
   assign zero_divisor = is_div(op_in) && (operandB == 32'd0);
   assign last_iter    = (count == CNT_W'(ITER_COUNT - 1));

   // NOTE: sequential state uses non-blocking (<=) so every register sees
   // pre-edge values of the others regardless of statement order.
   always_ff @(negedge clk or posedge reset) begin
      if (reset)            state <= ST_IDLE;
      else if (enableDebug) state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: if (start && !zero_divisor) next_state = ST_RUN;
         ST_RUN:  if (last_iter) next_state = ST_SIGN;
         ST_SIGN: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      load     = 1'b0;
      div_zero = 1'b0;
      iterate  = 1'b0;
      finish   = 1'b0;
      mtx_ok   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            load     = start && !zero_divisor;
            div_zero = start && zero_divisor;
            mtx_ok   = !start;   // a same-cycle start drops MTHI/MTLO
         end
         ST_RUN: begin
            busy    = 1'b1;
            iterate = 1'b1;
         end
         ST_SIGN: begin
            busy   = 1'b1;
            finish = 1'b1;
         end
         default: ;
      endcase
   end

   // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
   assign add_a = is_div(op_q) ? {hi_acc, lo_acc[31]} : {1'b0, hi_acc};

   mdu_addsub u_addsub (
      .a     (add_a),
      .b     ({1'b0, opnd}),
      .sub   (is_div(op_q)),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_comb begin
      mul_sum = lo_acc[0] ? add_sum : {1'b0, hi_acc};
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo_acc[31:1]};
      if (is_div(op_q)) begin
         hi_step = add_carry ? add_sum[31:0] : add_a[31:0];
         lo_step = {lo_acc[30:0], add_carry};
      end
   end

   always_comb begin
      product = neg_q ? -{hi_acc, lo_acc} : {hi_acc, lo_acc};
      res_hi  = product[63:32];
      res_lo  = product[31:0];
      if (is_div(op_q)) begin
         res_lo = neg_q     ? -lo_acc : lo_acc;
         res_hi = rem_neg_q ? -hi_acc : hi_acc;
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         op_q      <= OP_MULT;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         hi_acc    <= '0;
         lo_acc    <= '0;
         opnd      <= '0;
         done      <= 1'b0;
         divByZero <= 1'b0;
         hi_out    <= '0;
         lo_out    <= '0;
      end else if (enableDebug) begin
         done      <= finish || div_zero;
         divByZero <= div_zero;
         if (load) begin
            op_q      <= op_in;
            count     <= '0;
            neg_q     <= is_signed(op_in) && (operandA[31] ^ operandB[31]);
            rem_neg_q <= is_signed(op_in) && operandA[31];
            hi_acc    <= '0;
            opnd      <= is_div(op_in) ? magnitude(operandB, is_signed(op_in))
                                       : magnitude(operandA, is_signed(op_in));
            lo_acc    <= is_div(op_in) ? magnitude(operandA, is_signed(op_in))
                                       : magnitude(operandB, is_signed(op_in));
         end else if (iterate) begin
            hi_acc <= hi_step;
            lo_acc <= lo_step;
            count  <= last_iter ? '0 : count + 1'b1;
         end
         if (finish) begin
            hi_out <= res_hi;
            lo_out <= res_lo;
         end else if (mtx_ok) begin
            if (writeHi) hi_out <= wdata;
            if (writeLo) lo_out <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; samples 1 time unit after each
// falling (active) edge and drives inputs at the same point.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset, enableDebug, start, writeHi, writeLo;
   logic [1:0]  op;
   logic [31:0] operandA, operandB, wdata;
   logic        busy, done, divByZero;
   logic [31:0] hi_out, lo_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .enableDebug (enableDebug),
      .start       (start),
      .op          (op),
      .operandA    (operandA),
      .operandB    (operandB),
      .writeHi     (writeHi),
      .writeLo     (writeLo),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .divByZero   (divByZero),
      .hi_out      (hi_out),
      .lo_out      (lo_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; operandA = a; operandB = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 200) begin
         step();
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enableDebug = 1'b1; start = 1'b0; op = 2'b00;
      operandA = '0; operandB = '0; writeHi = 1'b0; writeLo = 1'b0; wdata = '0;
      step(); step();
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (divByZero !== 1'b0)  begin bad++; $display("FAIL reset_dbz got=%b want=0", divByZero); end
      total++; if (hi_out !== 32'd0)    begin bad++; $display("FAIL reset_hi got=%h want=0", hi_out); end
      total++; if (lo_out !== 32'd0)    begin bad++; $display("FAIL reset_lo got=%h want=0", lo_out); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_multiply();
      vec_t v[3];
      int   c;
      v[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      v[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      for (int i = 0; i < 3; i++) begin
         issue(v[i].o, v[i].a, v[i].b);
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul[%0d]_busy got=%b want=1", i, busy); end
         wait_done(c);
         total++; if (c != 33)          begin bad++; $display("FAIL mul[%0d]_latency got=%0d want=33", i, c); end
         total++; if (hi_out !== v[i].hi) begin bad++; $display("FAIL mul[%0d]_hi got=%h want=%h", i, hi_out, v[i].hi); end
         total++; if (lo_out !== v[i].lo) begin bad++; $display("FAIL mul[%0d]_lo got=%h want=%h", i, lo_out, v[i].lo); end
         total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mul[%0d]_idle got=%b want=0", i, busy); end
         step();
         total++; if (done !== 1'b0)    begin bad++; $display("FAIL mul[%0d]_pulse got=%b want=0", i, done); end
      end
   endtask

   task automatic test_divide();
      vec_t v[5];
      int   c;
      v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[1] = '{OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      v[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v[3] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      v[4] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
      for (int i = 0; i < 5; i++) begin
         issue(v[i].o, v[i].a, v[i].b);
         wait_done(c);
         total++; if (c != 33)            begin bad++; $display("FAIL div[%0d]_latency got=%0d want=33", i, c); end
         total++; if (hi_out !== v[i].hi) begin bad++; $display("FAIL div[%0d]_hi got=%h want=%h", i, hi_out, v[i].hi); end
         total++; if (lo_out !== v[i].lo) begin bad++; $display("FAIL div[%0d]_lo got=%h want=%h", i, lo_out, v[i].lo); end
         total++; if (divByZero !== 1'b0) begin bad++; $display("FAIL div[%0d]_dbz got=%b want=0", i, divByZero); end
         step();
      end
   endtask

   task automatic test_div_by_zero();
      writeHi = 1'b1; wdata = 32'h11;
      step();
      writeHi = 1'b0; writeLo = 1'b1; wdata = 32'h22;
      step();
      writeLo = 1'b0;
      total++; if (hi_out !== 32'h11) begin bad++; $display("FAIL mthi got=%h want=00000011", hi_out); end
      total++; if (lo_out !== 32'h22) begin bad++; $display("FAIL mtlo got=%h want=00000022", lo_out); end
      issue(OP_DIVU, 32'd5, 32'd0);
      total++; if (done !== 1'b1)      begin bad++; $display("FAIL dz_done got=%b want=1", done); end
      total++; if (divByZero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", divByZero); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL dz_busy got=%b want=0", busy); end
      total++; if (hi_out !== 32'h11)  begin bad++; $display("FAIL dz_hi got=%h want=00000011", hi_out); end
      total++; if (lo_out !== 32'h22)  begin bad++; $display("FAIL dz_lo got=%h want=00000022", lo_out); end
      step();
      total++; if (done !== 1'b0 || divByZero !== 1'b0)
         begin bad++; $display("FAIL dz_pulse got=%b%b want=00", done, divByZero); end
   endtask

   task automatic test_write_priority();
      int c;
      writeHi = 1'b1; wdata = 32'hDEADBEEF;
      issue(OP_MULTU, 32'd2, 32'd3);
      writeHi = 1'b0;
      total++; if (hi_out !== 32'h11) begin bad++; $display("FAIL start_wins got=%h want=00000011", hi_out); end
      step();
      writeLo = 1'b1; wdata = 32'hCAFEF00D;
      step();
      writeLo = 1'b0;
      total++; if (lo_out !== 32'h22) begin bad++; $display("FAIL busy_write got=%h want=00000022", lo_out); end
      wait_done(c);
      total++; if (c != 31)           begin bad++; $display("FAIL wp_latency got=%0d want=31", c); end
      total++; if (hi_out !== 32'd0)  begin bad++; $display("FAIL wp_hi got=%h want=0", hi_out); end
      total++; if (lo_out !== 32'd6)  begin bad++; $display("FAIL wp_lo got=%h want=6", lo_out); end
      step();
   endtask

   task automatic test_reset_mid_run();
      int c;
      issue(OP_MULTU, 32'h00001234, 32'h00000010);
      for (int i = 0; i < 10; i++) step();
      #2 reset = 1'b1;
      #1;
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      total++; if (hi_out !== 32'd0) begin bad++; $display("FAIL rst_mid_hi got=%h want=0", hi_out); end
      total++; if (lo_out !== 32'd0) begin bad++; $display("FAIL rst_mid_lo got=%h want=0", lo_out); end
      step();
      reset = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7);
      total++; if (busy !== 1'b1)    begin bad++; $display("FAIL rst_restart_busy got=%b want=1", busy); end
      wait_done(c);
      total++; if (c != 33)          begin bad++; $display("FAIL rst_restart_latency got=%0d want=33", c); end
      total++; if (hi_out !== 32'd2) begin bad++; $display("FAIL rst_restart_hi got=%h want=2", hi_out); end
      total++; if (lo_out !== 32'd14) begin bad++; $display("FAIL rst_restart_lo got=%h want=e", lo_out); end
      step();
   endtask

   task automatic test_stall();
      int   c;
      logic any_dbz = 1'b0;
      issue(OP_MULT, 32'd6, 32'hFFFFFFFB);
      op = OP_DIVU; operandA = '0; operandB = '0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         any_dbz |= divByZero;
      end
      start = 1'b0;
      total++; if (any_dbz !== 1'b0) begin bad++; $display("FAIL busy_start_dbz got=%b want=0", any_dbz); end
      step(); step();
      enableDebug = 1'b0;
      for (int i = 0; i < 5; i++) step();
      total++; if (busy !== 1'b1)    begin bad++; $display("FAIL frozen_busy got=%b want=1", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL frozen_done got=%b want=0", done); end
      enableDebug = 1'b1;
      wait_done(c);
      total++; if (c != 28)          begin bad++; $display("FAIL stall_latency got=%0d want=28", c); end
      total++; if (hi_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL stall_hi got=%h want=ffffffff", hi_out); end
      total++; if (lo_out !== 32'hFFFFFFE2) begin bad++; $display("FAIL stall_lo got=%h want=ffffffe2", lo_out); end
      enableDebug = 1'b0;
      step(); step();
      total++; if (done !== 1'b1)    begin bad++; $display("FAIL done_hold got=%b want=1", done); end
      enableDebug = 1'b1;
      step();
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL done_release got=%b want=0", done); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_div_by_zero();
      test_write_priority();
      test_reset_mid_run();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on falling edge, matching the pipeline latches.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: enableDebug  in  1  step enable; 0 freezes all state (reset still acts).
REQ-004 SHALL have: start  in  1  issue request, sampled only when idle.
REQ-005 SHALL have: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have: operandA  in  32  rs value (post-forwarding); operandB  in  32  rt value.
REQ-007 SHALL have: writeHi, writeLo  in  1 each  MTHI/MTLO strobes; wdata  in  32  their data.
REQ-008 SHALL have: busy  out  1  operation in progress, to the hazard unit for stall.
REQ-009 SHALL have: done  out  1  one-cycle completion pulse; divByZero  out  1  pulse coincident with done.
REQ-010 SHALL have: hi_out, lo_out  out  32 each  architectural HI/LO.

Function
REQ-011 SHALL implement states IDLE, RUN, SIGN; IDLE->RUN on start&&enableDebug; RUN->SIGN after 32 iterations; SIGN->IDLE.
REQ-012 SHALL sample operands and op at the start edge k; busy=1 after edge k through edge k+33.
REQ-013 SHALL perform one iteration per enabled edge k+1..k+32, 6-bit counter 0..31.
REQ-014 SHALL write HI/LO at edge k+33 (SIGN) and drive done=1 for the following cycle; result latency 33 enabled cycles.
REQ-015 MULT/MULTU: shift-add on magnitudes; {HI,LO} = 64-bit product.
REQ-016 DIV/DIVU: restoring division on magnitudes; LO=quotient, HI=remainder.
REQ-017 Signed ops: product/quotient negated if operand signs differ; remainder takes dividend sign.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no flag).
REQ-019 Divisor zero: no RUN; HI/LO unchanged; done and divByZero pulse in cycle after edge k; busy stays 0.
REQ-020 start while busy SHALL be ignored; the hazard unit guarantees stall.
REQ-021 writeHi/writeLo SHALL update HI/LO at the edge when idle; ignored while busy.
REQ-022 start and writeHi/writeLo in the same idle cycle: start wins, write dropped.
REQ-023 enableDebug=0 SHALL hold state, counter, busy; done pulse extends until next enabled edge.

Reset
REQ-024 reset SHALL immediately force state IDLE, counter 0, busy 0, done 0, divByZero 0, hi_out 0, lo_out 0.
REQ-025 reset mid-RUN SHALL abort the operation with no HI/LO write; new start is accepted at the first enabled edge after release.

Structure
REQ-026 Shared package SHALL hold op encodings, state encoding and ITER_COUNT=32.
REQ-027 One sub-module, mdu_addsub (33-bit add/subtract with carry out), SHALL serve both the multiply and divide iterations.

Verification
REQ-028 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done 33 cycles after start.
REQ-029 MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-030 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 DIVU 5/0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> done and divByZero one cycle later, HI/LO unchanged.
REQ-032 reset asserted at iteration 10 -> busy, hi_out, lo_out 0 without a clock edge; second start runs normally.
REQ-033 enableDebug low 5 cycles mid-RUN -> done delayed exactly 5 cycles with correct result; start during busy ignored.
